split_engine: RTL
=================

SPLIT_ENGINE -- requirements
Module: split_engine

Interface
REQ-001 Parameter: SRAM0_AW, default 16, SRAM0 byte-address width.
REQ-002 clk  input  1  rising-edge clock; one clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid  input  1  command strobe; sampled only in SP_IDLE.
REQ-005 cmd_src_base  input  16  byte base of the packed source tensor.
REQ-006 cmd_dst0_base / cmd_dst1_base  input  16 each  byte bases of the two destination tensors.
REQ-007 cmd_dst0_row_len / cmd_dst1_row_len  input  16 each  bytes per row sent to dst0 / dst1.
REQ-008 cmd_num_rows  input  16  row count.
REQ-009 sram_rd_en  output  1; sram_rd_addr  output  SRAM0_AW; sram_rd_data  input  8: SRAM0 read port, data valid the cycle after rd_en.
REQ-010 sram_wr_en  output  1; sram_wr_addr  output  SRAM0_AW; sram_wr_data  output  8: SRAM0 write port.
REQ-011 busy  output  1  high whenever state is not SP_IDLE.
REQ-012 done  output  1  single-cycle pulse in SP_DONE.

Function
REQ-013 The block SHALL perform the inverse of last-dimension concat: source row r is (L0+L1) bytes and is split into dst0 row r (first L0 bytes) and dst1 row r (remaining L1 bytes).
REQ-014 Addresses, all modulo 2^SRAM0_AW: src = src_base + r*(L0+L1) + b (dst0 phase) or + L0 + b (dst1 phase); dst0 = dst0_base + r*L0 + b; dst1 = dst1_base + r*L1 + b.
REQ-015 States: SP_IDLE, SP_COPY_DST0, SP_COPY_DST1, SP_NEXT_ROW, SP_DONE; SP_DONE always returns to SP_IDLE after one cycle.
REQ-016 On cmd_valid in SP_IDLE, all command fields SHALL be registered, L0+L1 precomputed, and row_idx, byte_idx, phase reset to 0; later changes to command inputs SHALL have no effect.
REQ-017 cmd_valid outside SP_IDLE SHALL be ignored (not queued).
REQ-018 Each byte takes 2 cycles: read cycle (rd_en=1, rd_addr=src), then write cycle (wr_en=1, wr_addr=dst, wr_data=sram_rd_data); rd_en and wr_en never both high.
REQ-019 From SP_IDLE accept or SP_NEXT_ROW->next row, the next state SHALL be SP_COPY_DST0 if L0!=0, else SP_COPY_DST1 if L1!=0, else SP_NEXT_ROW; zero-length segments consume no cycles.
REQ-020 After the write of byte L0-1 in SP_COPY_DST0: byte_idx<=0, go to SP_COPY_DST1 if L1!=0 else SP_NEXT_ROW; after byte L1-1 in SP_COPY_DST1: byte_idx<=0, go to SP_NEXT_ROW.
REQ-021 SP_NEXT_ROW SHALL increment row_idx, clear byte_idx and phase, and go to SP_DONE if row_idx == num_rows-1, else start next row per REQ-019.
REQ-022 num_rows == 0 SHALL go SP_IDLE -> SP_DONE directly with no SRAM access.
REQ-023 Latency: with num_rows=R>0, done SHALL be high exactly R*(2*(L0+L1)+1)+1 cycles after the accepting edge.
REQ-024 Outputs outside copy states SHALL be rd_en=0, wr_en=0, addresses 0, wr_data 0.

Reset
REQ-025 While rst_n=0: state SP_IDLE, busy=0, done=0, rd_en=0, wr_en=0, all addresses/data 0, all registers 0.
REQ-026 Reset asserted mid-operation SHALL abort immediately with no further SRAM writes; no resume after release.

Structure
REQ-027 The split opcode constant and command-field layout SHALL live in graph_isa_pkg; the state enum stays local to split_engine.
REQ-028 Single module, no sub-modules; address multiplies are combinational from registered fields.

Verification
REQ-029 src_base=0x100, L0=3, L1=2, R=2, src bytes 0..9 -> dst0_base=0x200 holds 0,1,2,5,6,7; dst1_base=0x300 holds 3,4,8,9; done at cycle 23.
REQ-030 L0=0, L1=4, R=1 -> no writes to dst0 region; dst1 gets src bytes 0..3; done at cycle 10.
REQ-031 L0=0, L1=0, R=3 -> no rd_en/wr_en ever high; done at cycle 4.
REQ-032 R=0 -> done pulses the cycle after accept, busy high exactly 1 cycle, no SRAM access.
REQ-033 Second cmd_valid pulsed mid-operation with different bases -> ignored, output identical to REQ-029.
REQ-034 rst_n dropped during the 3rd write of REQ-029 -> busy, rd_en, wr_en 0 immediately; a fresh command then completes correctly.

Source files
------------

// File: rtl/graph_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : graph_isa_pkg
// Purpose  : Shared graph-ISA definitions: the split opcode and the layout
//            of a split command as captured by split_engine.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package graph_isa_pkg;

  // Opcode assigned to the last-dimension split (inverse concat) operation.
  localparam logic [7:0] c_SPLIT_OPCODE = 8'h0B;

  // Command fields, all byte-granular.
  typedef struct packed {
    logic [15:0] src_base;
    logic [15:0] dst0_base;
    logic [15:0] dst1_base;
    logic [15:0] dst0_row_len;
    logic [15:0] dst1_row_len;
    logic [15:0] num_rows;
  } split_cmd_t;

endpackage
`default_nettype wire

// File: rtl/split_engine.sv
`default_nettype none
// ============================================================================
// Module   : split_engine
// Purpose  : Splits each packed source row of (L0+L1) bytes into a dst0 row
//            (first L0 bytes) and a dst1 row (last L1 bytes), one byte per
//            read/write cycle pair on a single SRAM port pair.
// Ports    : clk, rst_n (async, active-low)
//            cmd_valid + cmd_* fields  - command, accepted only when idle
//            sram_rd_en/addr, sram_rd_data - read port (data one cycle later)
//            sram_wr_en/addr/data      - write port
//            busy - not idle; done - one-cycle pulse at completion
// Revision : 1.0 - initial release
// ============================================================================
module split_engine
  import graph_isa_pkg::*;
#(
  parameter int SRAM0_AW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  input  logic [15:0]         cmd_src_base,
  input  logic [15:0]         cmd_dst0_base,
  input  logic [15:0]         cmd_dst1_base,
  input  logic [15:0]         cmd_dst0_row_len,
  input  logic [15:0]         cmd_dst1_row_len,
  input  logic [15:0]         cmd_num_rows,
  output logic                sram_rd_en,
  output logic [SRAM0_AW-1:0] sram_rd_addr,
  input  logic [7:0]          sram_rd_data,
  output logic                sram_wr_en,
  output logic [SRAM0_AW-1:0] sram_wr_addr,
  output logic [7:0]          sram_wr_data,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    SP_IDLE      = 3'd0,
    SP_COPY_DST0 = 3'd1,
    SP_COPY_DST1 = 3'd2,
    SP_NEXT_ROW  = 3'd3,
    SP_DONE      = 3'd4
  } sp_state_e;

  sp_state_e   r_state;
  split_cmd_t  r_cmd;
  logic [16:0] r_rowlen;   // L0+L1, one bit wider so it cannot wrap
  logic [15:0] r_row;
  logic [15:0] r_byte;
  logic        r_phase;    // 0 = read cycle, 1 = write cycle
  logic        r_busy;
  logic        r_done;

  // Row entry: skip empty segments so they cost no cycles.
  function automatic sp_state_e f_first_seg(input logic [15:0] l0,
                                            input logic [15:0] l1);
    if (l0 != 16'd0)      return SP_COPY_DST0;
    else if (l1 != 16'd0) return SP_COPY_DST1;
    else                  return SP_NEXT_ROW;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SP_IDLE;
      r_cmd    <= '0;
      r_rowlen <= '0;
      r_row    <= '0;
      r_byte   <= '0;
      r_phase  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        SP_IDLE: begin
          if (cmd_valid) begin
            r_cmd.src_base     <= cmd_src_base;
            r_cmd.dst0_base    <= cmd_dst0_base;
            r_cmd.dst1_base    <= cmd_dst1_base;
            r_cmd.dst0_row_len <= cmd_dst0_row_len;
            r_cmd.dst1_row_len <= cmd_dst1_row_len;
            r_cmd.num_rows     <= cmd_num_rows;
            r_rowlen <= {1'b0, cmd_dst0_row_len} + {1'b0, cmd_dst1_row_len};
            r_row    <= '0;
            r_byte   <= '0;
            r_phase  <= 1'b0;
            r_busy   <= 1'b1;
            if (cmd_num_rows == 16'd0) begin
              r_state <= SP_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= f_first_seg(cmd_dst0_row_len, cmd_dst1_row_len);
            end
          end
        end

        SP_COPY_DST0: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (16'(r_byte + 16'd1) == r_cmd.dst0_row_len) begin
              r_byte  <= '0;
              r_state <= (r_cmd.dst1_row_len != 16'd0) ? SP_COPY_DST1 : SP_NEXT_ROW;
            end else begin
              r_byte <= r_byte + 16'd1;
            end
          end
        end

        SP_COPY_DST1: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            if (16'(r_byte + 16'd1) == r_cmd.dst1_row_len) begin
              r_byte  <= '0;
              r_state <= SP_NEXT_ROW;
            end else begin
              r_byte <= r_byte + 16'd1;
            end
          end
        end

        SP_NEXT_ROW: begin
          r_row   <= r_row + 16'd1;
          r_byte  <= '0;
          r_phase <= 1'b0;
          if (16'(r_row + 16'd1) == r_cmd.num_rows) begin
            r_state <= SP_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= f_first_seg(r_cmd.dst0_row_len, r_cmd.dst1_row_len);
          end
        end

        SP_DONE: begin
          r_state <= SP_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= SP_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Address generation from registered fields; all sums wrap at SRAM0_AW.
  logic                w_copy0;
  logic                w_copy1;
  logic [32:0]         w_src_row_off;
  logic [31:0]         w_dst0_row_off;
  logic [31:0]         w_dst1_row_off;
  logic [SRAM0_AW-1:0] w_src_addr;
  logic [SRAM0_AW-1:0] w_dst_addr;

  assign w_copy0        = (r_state == SP_COPY_DST0);
  assign w_copy1        = (r_state == SP_COPY_DST1);
  assign w_src_row_off  = 33'(r_row) * 33'(r_rowlen);
  assign w_dst0_row_off = 32'(r_row) * 32'(r_cmd.dst0_row_len);
  assign w_dst1_row_off = 32'(r_row) * 32'(r_cmd.dst1_row_len);

  // In the dst1 phase the source pointer skips past the dst0 slice of the row.
  assign w_src_addr = SRAM0_AW'(r_cmd.src_base) + SRAM0_AW'(w_src_row_off)
                    + (w_copy1 ? SRAM0_AW'(r_cmd.dst0_row_len) : '0)
                    + SRAM0_AW'(r_byte);

  assign w_dst_addr = w_copy0
                    ? SRAM0_AW'(r_cmd.dst0_base) + SRAM0_AW'(w_dst0_row_off) + SRAM0_AW'(r_byte)
                    : SRAM0_AW'(r_cmd.dst1_base) + SRAM0_AW'(w_dst1_row_off) + SRAM0_AW'(r_byte);

  // Read data arrives in the write cycle, so it is forwarded straight through.
  assign sram_rd_en   = (w_copy0 | w_copy1) & ~r_phase;
  assign sram_wr_en   = (w_copy0 | w_copy1) &  r_phase;
  assign sram_rd_addr = sram_rd_en ? w_src_addr : '0;
  assign sram_wr_addr = sram_wr_en ? w_dst_addr : '0;
  assign sram_wr_data = sram_wr_en ? sram_rd_data : 8'h00;

  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire
